// File: rtl/poly_note_gen.sv
// Polyphonic square-wave note generator: CH independent voices with
// per-voice divider, sustain length, halving-decay release and stereo pan.
module poly_note_gen #(
  parameter int CH       = 4,
  parameter int DIV_W    = 22,
  parameter int AMP_W    = 15,
  parameter int LEN_W    = 16,
  parameter int TICK_DIV = 100000,
  localparam int CH_W    = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ld_valid,
  input  logic [CH_W-1:0]    ld_ch,
  input  logic [DIV_W-1:0]   ld_div,
  input  logic [AMP_W-1:0]   ld_amp,
  input  logic [LEN_W-1:0]   ld_len,
  input  logic [1:0]         ld_pan,
  input  logic [CH-1:0]      stop,
  output logic [CH-1:0]      busy,
  output logic signed [15:0] audio_left,
  output logic signed [15:0] audio_right
);

  localparam int PS_W  = $clog2(TICK_DIV);
  localparam int MIX_W = AMP_W + 1 + $clog2(CH) + 1;
  localparam int EXT_W = (MIX_W > 17) ? MIX_W : 17;
  localparam logic signed [EXT_W-1:0] SAT_MAX = 32767;
  localparam logic signed [EXT_W-1:0] SAT_MIN = -32768;

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, DECAY = 2'd2} vstate_t;

  logic [PS_W-1:0]  pre_cnt;
  logic             tick;

  vstate_t          state_q [CH];
  vstate_t          state_d [CH];
  logic [DIV_W-1:0] cnt_q   [CH];
  logic [DIV_W-1:0] cnt_d   [CH];
  logic [DIV_W-1:0] div_q   [CH];
  logic [DIV_W-1:0] div_d   [CH];
  logic             phase_q [CH];
  logic             phase_d [CH];
  logic [AMP_W-1:0] amp_q   [CH];
  logic [AMP_W-1:0] amp_d   [CH];
  logic [LEN_W-1:0] len_q   [CH];
  logic [LEN_W-1:0] len_d   [CH];
  logic [1:0]       pan_q   [CH];
  logic [1:0]       pan_d   [CH];

  logic signed [MIX_W-1:0] mix_l_p0;
  logic signed [MIX_W-1:0] mix_r_p0;

  function automatic logic signed [AMP_W:0] voice_val(input logic ph,
                                                      input logic [AMP_W-1:0] a);
    logic signed [AMP_W:0] m;
    m = $signed({1'b0, a});
    return ph ? m : -m;
  endfunction

  function automatic logic signed [15:0] sat16(input logic signed [MIX_W-1:0] x);
    logic signed [EXT_W-1:0] e;
    e = EXT_W'(x);
    if (e > SAT_MAX)      return 16'sh7fff;
    else if (e < SAT_MIN) return -16'sh8000;
    else                  return e[15:0];
  endfunction

  assign tick = (pre_cnt == PS_W'(TICK_DIV - 1));

  always_comb begin
    for (int i = 0; i < CH; i++) begin
      busy[i] = (state_q[i] != IDLE);
    end
  end

  // Voice next-state: a load overrides stop and tick events on the same voice
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      div_d[i]   = div_q[i];
      phase_d[i] = phase_q[i];
      amp_d[i]   = amp_q[i];
      len_d[i]   = len_q[i];
      pan_d[i]   = pan_q[i];
      if (ld_valid && (ld_ch == CH_W'(i))) begin
        state_d[i] = (ld_len == '0) ? DECAY : PLAY;
        cnt_d[i]   = '0;
        div_d[i]   = ld_div;
        phase_d[i] = 1'b0;
        amp_d[i]   = ld_amp;
        len_d[i]   = ld_len;
        pan_d[i]   = ld_pan;
      end else if (state_q[i] != IDLE) begin
        if (cnt_q[i] == div_q[i]) begin
          cnt_d[i]   = '0;
          phase_d[i] = ~phase_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DIV_W'(1);
        end
        if (state_q[i] == PLAY) begin
          if (tick) len_d[i] = len_q[i] - LEN_W'(1);
          if (stop[i] || (tick && (len_q[i] == LEN_W'(1)))) state_d[i] = DECAY;
        end else if (tick) begin
          amp_d[i] = amp_q[i] >> 1;
          if ((amp_q[i] >> 1) == '0) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
            phase_d[i] = 1'b0;
          end
        end
      end
    end
  end

  // Stage p0: combinational mix of the current voice registers
  always_comb begin
    mix_l_p0 = '0;
    mix_r_p0 = '0;
    for (int i = 0; i < CH; i++) begin
      if (state_q[i] != IDLE) begin
        if (pan_q[i][0]) mix_l_p0 = mix_l_p0 + MIX_W'(voice_val(phase_q[i], amp_q[i]));
        if (pan_q[i][1]) mix_r_p0 = mix_r_p0 + MIX_W'(voice_val(phase_q[i], amp_q[i]));
      end
    end
  end

  // Stage p1: saturated mix registered onto the outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt     <= '0;
      audio_left  <= '0;
      audio_right <= '0;
      for (int i = 0; i < CH; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
        div_q[i]   <= '0;
        phase_q[i] <= 1'b0;
        amp_q[i]   <= '0;
        len_q[i]   <= '0;
        pan_q[i]   <= '0;
      end
    end else begin
      pre_cnt     <= tick ? '0 : pre_cnt + PS_W'(1);
      audio_left  <= sat16(mix_l_p0);
      audio_right <= sat16(mix_r_p0);
      for (int i = 0; i < CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        div_q[i]   <= div_d[i];
        phase_q[i] <= phase_d[i];
        amp_q[i]   <= amp_d[i];
        len_q[i]   <= len_d[i];
        pan_q[i]   <= pan_d[i];
      end
    end
  end

endmodule
